// File: rtl/split_acc_bank.sv
// Bank of CHANNELS accumulators fed by a valid/ready command stream, answered in order on a
// valid/ready response stream. Define SPLIT_ACC_SAT_EN to saturate instead of wrapping.
module split_acc_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int CH_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [CH_W-1:0]           cmd_ch,
  input  logic [1:0]                cmd_op,
  input  logic [WIDTH-1:0]          cmd_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [CH_W-1:0]           rsp_ch,
  output logic [WIDTH-1:0]          rsp_data,
  output logic                      rsp_err,
  output logic [CHANNELS*WIDTH-1:0] acc_flat,
  output logic [CHANNELS-1:0]       ovf_flags
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(CHANNELS);

`ifdef SPLIT_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic             s1_valid;
  logic [CH_W-1:0]  s1_ch;
  logic [1:0]       s1_op;
  logic [WIDTH-1:0] s1_data;
  logic             s1_err;
  logic             adv;
  logic             fire;

  (* isolate_assignments *) logic [WIDTH-1:0] acc [CHANNELS];
  (* isolate_assignments *) logic [WIDTH-1:0] rsp_data_q;

  logic [WIDTH-1:0] cur_acc;
  logic [WIDTH-1:0] nxt_acc;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             ovf_set;
  logic             ovf_clr;

  assign adv       = !rsp_valid || rsp_ready;
  assign cmd_ready = !rst && (!s1_valid || adv);
  assign fire      = s1_valid && adv;
  assign s1_err    = {1'b0, s1_ch} >= CH_LIM;
  assign rsp_data  = rsp_data_q;

  always_comb begin
    cur_acc = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (s1_ch == CH_W'(i)) cur_acc = acc[i];
    end
    sum     = {1'b0, cur_acc} + {1'b0, s1_data};
    diff    = {1'b0, cur_acc} - {1'b0, s1_data};
    nxt_acc = cur_acc;
    ovf_set = 1'b0;
    ovf_clr = 1'b0;
    case (s1_op)
      OP_ADD: begin
        ovf_set = sum[WIDTH];
        nxt_acc = (SAT_EN && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
      end
      OP_SUB: begin
        // The extra MSB of the difference is the borrow (data > acc).
        ovf_set = diff[WIDTH];
        nxt_acc = (SAT_EN && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
      end
      OP_LOAD: begin
        nxt_acc = s1_data;
        ovf_clr = 1'b1;
      end
      default: begin
        nxt_acc = '0;
        ovf_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_ch      <= '0;
      s1_op      <= '0;
      s1_data    <= '0;
      rsp_valid  <= 1'b0;
      rsp_ch     <= '0;
      rsp_data_q <= '0;
      rsp_err    <= 1'b0;
      ovf_flags  <= '0;
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        s1_valid <= 1'b1;
        s1_ch    <= cmd_ch;
        s1_op    <= cmd_op;
        s1_data  <= cmd_data;
      end else if (adv) begin
        s1_valid <= 1'b0;
      end

      // Accumulator is written in the same edge the response is loaded, so a following
      // command to the same channel reads the updated value without forwarding.
      if (fire) begin
        rsp_valid  <= 1'b1;
        rsp_ch     <= s1_ch;
        rsp_err    <= s1_err;
        rsp_data_q <= s1_err ? '0 : nxt_acc;
        for (int i = 0; i < CHANNELS; i++) begin
          if (!s1_err && s1_ch == CH_W'(i)) begin
            acc[i] <= nxt_acc;
            if (ovf_clr)      ovf_flags[i] <= 1'b0;
            else if (ovf_set) ovf_flags[i] <= 1'b1;
          end
        end
      end else if (adv) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    acc_flat = '0;
    for (int i = 0; i < CHANNELS; i++) acc_flat[i*WIDTH +: WIDTH] = acc[i];
  end

endmodule

// File: tb/tb_split_acc_bank.sv
// Self-checking bench for split_acc_bank: directed scenarios plus randomized traffic
// compared against an arithmetic reference model.
module tb_split_acc_bank;

`ifdef SPLIT_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_ch, cmd_op;
  logic [7:0]  cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_ch;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [31:0] acc_flat;
  logic [3:0]  ovf_flags;

  logic        c3_cmd_valid, c3_cmd_ready;
  logic [1:0]  c3_cmd_ch, c3_cmd_op;
  logic [7:0]  c3_cmd_data;
  logic        c3_rsp_valid, c3_rsp_ready;
  logic [1:0]  c3_rsp_ch;
  logic [7:0]  c3_rsp_data;
  logic        c3_rsp_err;
  logic [23:0] c3_acc_flat;
  logic [2:0]  c3_ovf_flags;

  int checks   = 0;
  int failures = 0;

  int m_acc [4];
  bit m_ovf [4];

  always #5 clk = ~clk;

  split_acc_bank #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_ch(rsp_ch), .rsp_data(rsp_data), .rsp_err(rsp_err), .acc_flat(acc_flat),
    .ovf_flags(ovf_flags)
  );

  split_acc_bank #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(c3_cmd_valid), .cmd_ready(c3_cmd_ready),
    .cmd_ch(c3_cmd_ch), .cmd_op(c3_cmd_op), .cmd_data(c3_cmd_data),
    .rsp_valid(c3_rsp_valid), .rsp_ready(c3_rsp_ready), .rsp_ch(c3_rsp_ch),
    .rsp_data(c3_rsp_data), .rsp_err(c3_rsp_err), .acc_flat(c3_acc_flat),
    .ovf_flags(c3_ovf_flags)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one command and hold it until the handshake edge has passed.
  task automatic send1(input logic [1:0] ch, input logic [1:0] op, input logic [7:0] d,
                       output bit ok);
    cmd_ch = ch; cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      if (cmd_ready) ok = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok, output logic [7:0] d);
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      if (rsp_valid) begin
        ok = 1'b1;
        d  = rsp_data;
      end
      tick();
    end
  endtask

  function automatic logic [7:0] model_step(int ch, int op, int d);
    int s;
    case (op)
      0: begin
        s = m_acc[ch] + d;
        if (s >= 256) begin m_ovf[ch] = 1'b1; s = SAT ? 255 : s - 256; end
      end
      1: begin
        s = m_acc[ch] - d;
        if (s < 0) begin m_ovf[ch] = 1'b1; s = SAT ? 0 : s + 256; end
      end
      2: begin s = d; m_ovf[ch] = 1'b0; end
      default: begin s = 0; m_ovf[ch] = 1'b0; end
    endcase
    m_acc[ch] = s;
    return 8'(s);
  endfunction

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    c3_cmd_valid = 1'b0; c3_rsp_ready = 1'b1;
    cmd_ch = '0; cmd_op = '0; cmd_data = '0;
    c3_cmd_ch = '0; c3_cmd_op = '0; c3_cmd_data = '0;
    tick(); tick(); tick();
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
    checks++;
    if ({rsp_valid, rsp_ch, rsp_data, rsp_err} !== 12'h000) begin
      failures++; $display("FAIL reset_rsp got=%h exp=000", {rsp_valid, rsp_ch, rsp_data, rsp_err});
    end
    checks++;
    if ({acc_flat, ovf_flags} !== 36'h0) begin
      failures++; $display("FAIL reset_state got=%h exp=0", {acc_flat, ovf_flags});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", cmd_ready); end
    tick();
  endtask

  task automatic test_back_to_back();
    cmd_ch = 2'd1; cmd_op = 2'b00; cmd_data = 8'h10; cmd_valid = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", cmd_ready); end
    tick();
    #1;
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      failures++; $display("FAIL b2b_latency got=%b exp=10", {cmd_ready, rsp_valid});
    end
    tick();
    cmd_valid = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_ch, rsp_data} !== {1'b1, 2'd1, 8'h10}) begin
      failures++; $display("FAIL b2b_rsp0 got=%h exp=%h", {rsp_valid, rsp_ch, rsp_data}, {1'b1, 2'd1, 8'h10});
    end
    tick();
    #1;
    checks++;
    if ({rsp_valid, rsp_ch, rsp_data} !== {1'b1, 2'd1, 8'h20}) begin
      failures++; $display("FAIL b2b_rsp1 got=%h exp=%h", {rsp_valid, rsp_ch, rsp_data}, {1'b1, 2'd1, 8'h20});
    end
    tick();
    #1;
    checks++;
    if ({rsp_valid, acc_flat[15:8], ovf_flags} !== {1'b0, 8'h20, 4'h0}) begin
      failures++; $display("FAIL b2b_final got=%h exp=%h", {rsp_valid, acc_flat[15:8], ovf_flags}, {1'b0, 8'h20, 4'h0});
    end
    tick();
  endtask

  task automatic test_overflow();
    bit ok_c, ok_r;
    logic [7:0] d;
    send1(2'd2, 2'b10, 8'hF0, ok_c); wait_rsp(ok_r, d);
    checks++;
    if (!(ok_c && ok_r) || d !== 8'hF0) begin failures++; $display("FAIL ovf_load got=%h exp=f0", d); end
    send1(2'd2, 2'b00, 8'h20, ok_c); wait_rsp(ok_r, d);
    checks++;
    if (!(ok_c && ok_r) || d !== (SAT ? 8'hFF : 8'h10)) begin
      failures++; $display("FAIL ovf_add got=%h exp=%h", d, SAT ? 8'hFF : 8'h10);
    end
    checks++;
    if (ovf_flags !== 4'b0100) begin failures++; $display("FAIL ovf_flag_set got=%b exp=0100", ovf_flags); end
    send1(2'd2, 2'b11, 8'h5A, ok_c); wait_rsp(ok_r, d);
    checks++;
    if (!(ok_c && ok_r) || d !== 8'h00 || ovf_flags !== 4'b0000) begin
      failures++; $display("FAIL ovf_clear got=%h/%b exp=00/0000", d, ovf_flags);
    end
  endtask

  task automatic test_underflow();
    bit ok_c, ok_r;
    logic [7:0] d;
    send1(2'd0, 2'b01, 8'h01, ok_c); wait_rsp(ok_r, d);
    checks++;
    if (!(ok_c && ok_r) || d !== (SAT ? 8'h00 : 8'hFF)) begin
      failures++; $display("FAIL sub_rsp got=%h exp=%h", d, SAT ? 8'h00 : 8'hFF);
    end
    checks++;
    if (ovf_flags !== 4'b0001) begin failures++; $display("FAIL sub_flag got=%b exp=0001", ovf_flags); end
    checks++;
    if (acc_flat !== {8'h00, 8'h00, 8'h20, (SAT ? 8'h00 : 8'hFF)}) begin
      failures++; $display("FAIL sub_others got=%h exp=%h", acc_flat, {8'h00, 8'h00, 8'h20, (SAT ? 8'h00 : 8'hFF)});
    end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    int stable = 0;
    int bad = 0;
    logic [7:0] got [$];
    bit clr;
    rsp_ready = 1'b0;
    cmd_ch = 2'd3; cmd_op = 2'b00; cmd_data = 8'h01; cmd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (cmd_valid && cmd_ready) accepted++;
      if (rsp_valid) begin
        stable++;
        if (rsp_data !== 8'h01 || rsp_ch !== 2'd3) bad++;
      end
      tick();
    end
    #1;
    checks++;
    if (accepted !== 2 || cmd_ready !== 1'b0) begin
      failures++; $display("FAIL bp_accept got=%0d/%b exp=2/0", accepted, cmd_ready);
    end
    checks++;
    if (stable !== 6 || bad !== 0) begin
      failures++; $display("FAIL bp_stable got=%0d/%0d exp=6/0", stable, bad);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      clr = cmd_valid && cmd_ready;
      if (clr) accepted++;
      if (rsp_valid) got.push_back(rsp_data);
      tick();
      if (clr) cmd_valid = 1'b0;
    end
    checks++;
    if (accepted !== 3 || got.size() !== 3) begin
      failures++; $display("FAIL bp_count got=%0d/%0d exp=3/3", accepted, got.size());
    end else begin
      checks++;
      if ({got[0], got[1], got[2]} !== 24'h010203) begin
        failures++; $display("FAIL bp_order got=%h exp=010203", {got[0], got[1], got[2]});
      end
    end
  endtask

  task automatic test_bad_channel();
    c3_rsp_ready = 1'b1;
    c3_cmd_ch = 2'd2; c3_cmd_op = 2'b00; c3_cmd_data = 8'h07; c3_cmd_valid = 1'b1;
    tick();
    c3_cmd_ch = 2'd3; c3_cmd_data = 8'h55;
    tick();
    c3_cmd_valid = 1'b0;
    #1;
    checks++;
    if ({c3_rsp_valid, c3_rsp_err, c3_rsp_data} !== {1'b1, 1'b0, 8'h07}) begin
      failures++; $display("FAIL ch3_good got=%h exp=%h", {c3_rsp_valid, c3_rsp_err, c3_rsp_data}, {1'b1, 1'b0, 8'h07});
    end
    tick();
    #1;
    checks++;
    if ({c3_rsp_valid, c3_rsp_err, c3_rsp_ch, c3_rsp_data} !== {1'b1, 1'b1, 2'd3, 8'h00}) begin
      failures++; $display("FAIL ch3_err got=%h exp=%h", {c3_rsp_valid, c3_rsp_err, c3_rsp_ch, c3_rsp_data}, {1'b1, 1'b1, 2'd3, 8'h00});
    end
    tick();
    #1;
    checks++;
    if ({c3_acc_flat, c3_ovf_flags} !== {24'h070000, 3'b000}) begin
      failures++; $display("FAIL ch3_state got=%h exp=%h", {c3_acc_flat, c3_ovf_flags}, {24'h070000, 3'b000});
    end
    tick();
  endtask

  task automatic test_reset_inflight();
    int bad = 0;
    rsp_ready = 1'b0;
    cmd_ch = 2'd0; cmd_op = 2'b10; cmd_data = 8'h33; cmd_valid = 1'b1;
    tick();
    cmd_ch = 2'd1; cmd_op = 2'b00; cmd_data = 8'h01;
    tick();
    cmd_valid = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b exp=1", rsp_valid); end
    rst = 1'b1;
    tick();
    #1;
    checks++;
    if ({rsp_valid, cmd_ready, acc_flat, ovf_flags} !== 38'h0) begin
      failures++; $display("FAIL rst_inflight got=%h exp=0", {rsp_valid, cmd_ready, acc_flat, ovf_flags});
    end
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (rsp_valid) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL rst_no_rsp got=%0d exp=0", bad); end
  endtask

  task automatic test_random();
    logic [10:0] exp_q [$];
    logic [10:0] e;
    bit pending = 1'b0;
    logic [31:0] exp_flat;
    logic [3:0]  exp_ovf;
    for (int c = 0; c < 4; c++) begin m_acc[c] = 0; m_ovf[c] = 1'b0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!pending) begin
        cmd_valid = ($urandom_range(0, 3) != 0);
        cmd_ch    = 2'($urandom_range(0, 3));
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_data  = 8'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rand_extra_rsp got=%h exp=none", {rsp_err, rsp_ch, rsp_data});
        end else begin
          e = exp_q.pop_front();
          if ({rsp_err, rsp_ch, rsp_data} !== e) begin
            failures++; $display("FAIL rand_rsp got=%h exp=%h", {rsp_err, rsp_ch, rsp_data}, e);
          end
        end
      end
      if (cmd_valid && cmd_ready) begin
        e = {1'b0, cmd_ch, model_step(int'(cmd_ch), int'(cmd_op), int'(cmd_data))};
        exp_q.push_back(e);
        pending = 1'b0;
      end else begin
        pending = cmd_valid;
      end
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rand_extra_rsp got=%h exp=none", {rsp_err, rsp_ch, rsp_data});
        end else begin
          e = exp_q.pop_front();
          if ({rsp_err, rsp_ch, rsp_data} !== e) begin
            failures++; $display("FAIL rand_rsp got=%h exp=%h", {rsp_err, rsp_ch, rsp_data}, e);
          end
        end
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rand_missing got=%0d exp=0", exp_q.size()); end
    for (int c = 0; c < 4; c++) begin
      exp_flat[c*8 +: 8] = 8'(m_acc[c]);
      exp_ovf[c] = m_ovf[c];
    end
    checks++;
    if ({acc_flat, ovf_flags} !== {exp_flat, exp_ovf}) begin
      failures++; $display("FAIL rand_final got=%h exp=%h", {acc_flat, ovf_flags}, {exp_flat, exp_ovf});
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_overflow();
    test_underflow();
    test_backpressure();
    test_bad_channel();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
